// File: rtl/fifo_word_packer_if.sv
// Bus bundle for fifo_word_packer.
//   Upstream FIFO side : empty, read_data (into packer), pop (out of packer)
//   Control            : flush (into packer)
//   Downstream side    : out_valid, out_data, out_count (out of packer), out_ready (into packer)
// Modports:
//   master - the environment (drives FIFO status, flush, out_ready)
//   slave  - the packer itself
interface fifo_word_packer_if #(
  parameter int width = 8,
  parameter int ratio = 4
);
  localparam int count_w = $clog2(ratio + 1);

  logic                     empty;
  logic [width-1:0]         read_data;
  logic                     pop;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [width*ratio-1:0]   out_data;
  logic [count_w-1:0]       out_count;

  modport master (
    output empty, read_data, flush, out_ready,
    input  pop, out_valid, out_data, out_count
  );

  modport slave (
    input  empty, read_data, flush, out_ready,
    output pop, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops words from an upstream FIFO and packs `ratio` of
// them into one wide packet, first-popped word in the lowest lane. A flush
// emits a partially filled packet (unused lanes zero) with out_count giving
// the number of valid words.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - fifo_word_packer_if.slave (FIFO pop side, flush, output handshake)
// Datapath: assembly register (lanes 0..ratio-1) + lane counter, feeding a
// single output holding register. Sustains one word per cycle with no bubble
// between packets because the last lane may be popped in the same cycle the
// held packet is being accepted.
module fifo_word_packer #(
  parameter int width = 8,
  parameter int ratio = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_word_packer_if.slave  bus
);

  localparam int cnt_w   = $clog2(ratio);
  localparam int count_w = $clog2(ratio + 1);

  logic [cnt_w-1:0]              cnt_q, cnt_d;
  logic [ratio-1:0][width-1:0]   asm_q, asm_d, asm_next;
  logic                          out_valid_q, out_valid_d;
  logic [width*ratio-1:0]        out_data_q, out_data_d;
  logic [count_w-1:0]            out_count_q, out_count_d;

  logic out_free;
  logic last_lane;
  logic pop;
  logic flush_go;
  logic emit;

  // NOTE: every signal assigned in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    out_free  = ~out_valid_q | bus.out_ready;
    last_lane = (cnt_q == cnt_w'(ratio - 1));
    // Lanes below the last can always accept; the last lane only when the
    // finished packet has somewhere to go. Gated by rst so pop stays low
    // throughout reset.
    pop       = rst & ~bus.empty & (~last_lane | out_free);
    // A same-cycle pop counts as content, so a flush with cnt==0 still emits
    // when a word is arriving.
    flush_go  = bus.flush & out_free & ((cnt_q != '0) | pop);
    emit      = (pop & last_lane) | flush_go;

    asm_next = asm_q;
    if (pop) asm_next[cnt_q] = bus.read_data;

    asm_d       = asm_next;
    cnt_d       = cnt_q + cnt_w'(pop);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    if (bus.out_ready) out_valid_d = 1'b0;

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = asm_next;
      out_count_d = count_w'(cnt_q) + count_w'(pop);
      // Clearing here keeps unwritten lanes at zero for the next packet.
      asm_d       = '0;
      cnt_d       = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values; the assembly register is reset as well
  // because the zero-fill of unused lanes depends on it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.pop       = pop;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

  localparam int width = 8;
  localparam int ratio = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_word_packer_if #(.width(width), .ratio(ratio)) bus ();
  fifo_word_packer #(.width(width), .ratio(ratio)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  logic [width-1:0] fifo_q[$];     // upstream FIFO model
  logic [width-1:0] exp_words[$];  // scoreboard: words still to be delivered
  int pkt_cnt  = 0;
  int last_cnt = 0;

  typedef struct {
    logic        empty;
    logic [7:0]  rd;
    logic        flush;
    logic        ready;
    logic        exp_pop;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic score_packet(input logic [31:0] data, input logic [2:0] cnt);
    logic [width-1:0] lane;
    last_cnt = int'(cnt);
    pkt_cnt++;
    check("count_range", 64'((cnt >= 3'd1) && (cnt <= 3'd4)), 64'd1);
    for (int i = 0; i < ratio; i++) begin
      lane = data[i*width +: width];
      if (i < int'(cnt)) begin
        if (exp_words.size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else check("lane_word", 64'(lane), 64'(exp_words.pop_front()));
      end else begin
        check("unused_lane", 64'(lane), 64'd0);
      end
    end
  endtask

  task automatic push_word(input logic [width-1:0] w);
    fifo_q.push_back(w);
    exp_words.push_back(w);
  endtask

  // Called at a negedge, returns at the next negedge.
  task automatic fifo_cycle(input logic fl, input logic rdy, output logic popped, output logic xfer);
    bus.empty     = (fifo_q.size() == 0);
    bus.read_data = bus.empty ? '0 : fifo_q[0];
    bus.flush     = fl;
    bus.out_ready = rdy;
    #1;
    popped = bus.pop;
    check("pop_while_empty", 64'(popped & bus.empty), 64'd0);
    xfer = bus.out_valid & rdy;
    if (xfer) score_packet(bus.out_data, bus.out_count);
    @(posedge clk);
    if (popped) void'(fifo_q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    logic p, x;
    int pops;
    logic [31:0] held;
    int n;

    //             empty rd     fl  rdy pop val data          cnt
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    vecs[1]  = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    vecs[2]  = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    vecs[3]  = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33221100, 3'd4};
    vecs[4]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[5]  = '{1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    vecs[6]  = '{1'b0, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    vecs[7]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000BBAA, 3'd2};
    vecs[8]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[9]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[10] = '{1'b0, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, 32'h000000CC, 3'd1};
    vecs[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h000000CC, 3'd1};
    vecs[12] = '{1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 32'h000000CC, 3'd1};
    vecs[13] = '{1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000CC, 3'd1};
    vecs[14] = '{1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000CC, 3'd1};
    vecs[15] = '{1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 32'h000000CC, 3'd1};
    vecs[16] = '{1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 3'd4};
    vecs[17] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[18] = '{1'b0, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    vecs[19] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000005, 3'd1};
    vecs[20] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0};

    // Reset state, with a word presented so pop gating by reset is visible.
    bus.empty = 1'b0; bus.read_data = 8'h5A; bus.flush = 1'b1; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pop",       64'(bus.pop),       64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);

    // Table-driven single-cycle vectors; first pop happens on the first edge
    // after reset release.
    rst = 1'b1;
    for (int i = 0; i < 21; i++) begin
      bus.empty = vecs[i].empty; bus.read_data = vecs[i].rd;
      bus.flush = vecs[i].flush; bus.out_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d_pop", i), 64'(bus.pop), 64'(vecs[i].exp_pop));
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_data", i),  64'(bus.out_data),  64'(vecs[i].exp_data));
        check($sformatf("vec%0d_count", i), 64'(bus.out_count), 64'(vecs[i].exp_count));
      end
      @(negedge clk);
    end

    // Back-to-back stream of 12 words: pop never drops, packets every 4 cycles.
    for (int i = 0; i < 12; i++) push_word(8'(i * 8'h11));
    for (int i = 0; i < 16; i++) begin
      fifo_cycle(1'b0, 1'b1, p, x);
      if (i < 12) check("stream_pop", 64'(p), 64'd1);
      check("stream_xfer", 64'(x), 64'((i == 4) || (i == 8) || (i == 12)));
    end
    check("stream_pkts", 64'(pkt_cnt), 64'd3);

    // Backpressure: first packet held, pop stalls with 7 words popped.
    for (int i = 0; i < 8; i++) push_word(8'(i * 8'h11));
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      fifo_cycle(1'b0, 1'b0, p, x);
      if (p) pops++;
    end
    check("bp_pops", 64'(pops), 64'd7);
    check("bp_fifo_left", 64'(fifo_q.size()), 64'd1);
    check("bp_valid", 64'(bus.out_valid), 64'd1);
    held = bus.out_data;
    check("bp_data", 64'(held), 64'h33221100);
    fifo_cycle(1'b0, 1'b0, p, x);
    check("bp_stable", 64'(bus.out_data), 64'(held));
    n = 0;
    while ((exp_words.size() != 0 || bus.out_valid) && n < 20) begin
      fifo_cycle(1'b0, 1'b1, p, x);
      n++;
    end
    check("bp_drained", 64'(exp_words.size()), 64'd0);
    check("bp_pkts", 64'(pkt_cnt), 64'd5);

    // Reset mid-packet: two popped words are discarded.
    for (int i = 0; i < 5; i++) push_word(8'h50 + 8'(i));
    fifo_cycle(1'b0, 1'b1, p, x);
    fifo_cycle(1'b0, 1'b1, p, x);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fifo_cycle(1'b0, 1'b1, p, x);
      check("midrst_pop", 64'(p), 64'd0);
      check("midrst_valid", 64'(bus.out_valid), 64'd0);
    end
    exp_words = fifo_q;
    rst = 1'b1;
    push_word(8'h55);
    n = pkt_cnt;
    for (int i = 0; i < 8; i++) fifo_cycle(1'b0, 1'b1, p, x);
    check("midrst_pkts", 64'(pkt_cnt - n), 64'd1);
    check("midrst_count", 64'(last_cnt), 64'd4);

    // Random empty / out_ready / flush against the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0) push_word(8'($urandom));
      fifo_cycle(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0), p, x);
    end
    n = 0;
    while ((exp_words.size() != 0 || bus.out_valid) && n < 200) begin
      fifo_cycle(1'b1, 1'b1, p, x);
      n++;
    end
    check("rand_drained", 64'(exp_words.size()), 64'd0);
    check("rand_fifo_empty", 64'(fifo_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
